// File: rtl/prm_edge_pkg.sv
// Shared types and helpers for the PRM edge mask engine: cube entry layout,
// FSM states and small width/popcount utilities.
package prm_edge_pkg;

  localparam int unsigned CUBE_W_MAX   = 32;
  localparam int unsigned EDGE_W_MAX   = 16;
  localparam int unsigned POP_W_MAX    = 512;

  localparam int unsigned DEF_IN_W     = 15;
  localparam int unsigned DEF_N_EDGE   = 128;
  localparam int unsigned DEF_DEPTH    = 256;
  localparam int unsigned DEF_LANES    = 4;
  localparam int unsigned DEF_SCAN_LEN = DEF_DEPTH / DEF_LANES;

  // Stored fields are zero-extended to fixed maximum widths so the struct is
  // independent of the engine's parameters.
  typedef struct packed {
    logic [CUBE_W_MAX-1:0] care;
    logic [CUBE_W_MAX-1:0] val;
    logic [EDGE_W_MAX-1:0] edge_idx;
    logic                  en;
  } cube_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Index width for n items, never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

  function automatic int unsigned popcount(input logic [POP_W_MAX-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < POP_W_MAX; i++) c += 32'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/prm_cube_match.sv
// One evaluation lane: tests a single cube against the query vector.
module prm_cube_match
  import prm_edge_pkg::*;
(
  input  cube_t                 cube,
  input  logic [CUBE_W_MAX-1:0] q_vec,
  output logic                  hit_c,
  output logic [EDGE_W_MAX-1:0] edge_idx_c
);

  assign hit_c      = cube.en && (((q_vec ^ cube.val) & cube.care) == '0);
  assign edge_idx_c = cube.edge_idx;

endmodule

// File: rtl/prm_edge_mask_engine.sv
// Reloadable sum-of-products edge checker: scans a cube table LANES entries
// per cycle and reports one blocked bit per roadmap edge.
module prm_edge_mask_engine
  import prm_edge_pkg::*;
#(
  parameter  int unsigned IN_W     = 15,
  parameter  int unsigned N_EDGE   = 128,
  parameter  int unsigned DEPTH    = 256,
  parameter  int unsigned LANES    = 4,
  localparam int unsigned ADDR_W   = idx_w(DEPTH),
  localparam int unsigned EDGE_W   = idx_w(N_EDGE),
  localparam int unsigned HITS_W   = idx_w(N_EDGE + 1)
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic              cfg_clr,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [IN_W-1:0]   cfg_care,
  input  logic [IN_W-1:0]   cfg_val,
  input  logic [EDGE_W-1:0] cfg_edge,
  input  logic              cfg_en,
  input  logic              q_valid,
  output logic              q_ready,
  input  logic [IN_W-1:0]   q_vec,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [N_EDGE-1:0] r_mask,
  output logic [HITS_W-1:0] r_hits
);

  localparam int unsigned SCAN_LEN = DEPTH / LANES;
  localparam int unsigned PTR_W    = idx_w(SCAN_LEN);

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [N_EDGE-1:0]     mask_q, mask_d;
  logic [CUBE_W_MAX-1:0] qv_q, qv_d;
  cube_t                 cube_q [DEPTH];
  cube_t                 cube_d [DEPTH];
  logic                  q_ready_q, q_ready_d;
  logic                  cfg_ready_q, cfg_ready_d;
  logic                  r_valid_q, r_valid_d;

  cube_t                 lane_cube    [LANES];
  logic [LANES-1:0]      lane_hit_c;
  logic [EDGE_W_MAX-1:0] lane_edge_c  [LANES];

  // Lane l reads entry ptr*LANES + l of the current group.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_cube[l] = cube_q[ADDR_W'((32'(ptr_q) * LANES) + 32'(l))];
    prm_cube_match u_match (
      .cube       (lane_cube[l]),
      .q_vec      (qv_q),
      .hit_c      (lane_hit_c[l]),
      .edge_idx_c (lane_edge_c[l])
    );
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mask_d  = mask_q;
    qv_d    = qv_q;
    cube_d  = cube_q;

    // Clear precedes write so a same-cycle write survives.
    if (cfg_ready_q && cfg_clr) begin
      for (int i = 0; i < DEPTH; i++) cube_d[i].en = 1'b0;
    end
    if (cfg_ready_q && cfg_we) begin
      cube_d[cfg_addr] = '{care:     CUBE_W_MAX'(cfg_care),
                           val:      CUBE_W_MAX'(cfg_val),
                           edge_idx: EDGE_W_MAX'(cfg_edge),
                           en:       cfg_en};
    end

    unique case (state_q)
      ST_IDLE: begin
        if (q_valid && q_ready_q) begin
          qv_d    = CUBE_W_MAX'(q_vec);
          mask_d  = '0;
          ptr_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        for (int l = 0; l < LANES; l++) begin
          for (int e = 0; e < N_EDGE; e++) begin
            if (lane_hit_c[l] && (lane_edge_c[l] == EDGE_W_MAX'(e))) mask_d[e] = 1'b1;
          end
        end
        if (ptr_q == PTR_W'(SCAN_LEN - 1)) begin
          ptr_d   = '0;
          state_d = ST_DONE;
        end else begin
          ptr_d = ptr_q + PTR_W'(1);
        end
      end
      ST_DONE: begin
        if (r_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    q_ready_d   = (state_d == ST_IDLE);
    cfg_ready_d = (state_d == ST_IDLE);
    r_valid_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      mask_q      <= '0;
      qv_q        <= '0;
      q_ready_q   <= 1'b0;
      cfg_ready_q <= 1'b0;
      r_valid_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) cube_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      mask_q      <= mask_d;
      qv_q        <= qv_d;
      q_ready_q   <= q_ready_d;
      cfg_ready_q <= cfg_ready_d;
      r_valid_q   <= r_valid_d;
      cube_q      <= cube_d;
    end
  end

  assign q_ready   = q_ready_q;
  assign cfg_ready = cfg_ready_q;
  assign r_valid   = r_valid_q;
  assign r_mask    = mask_q;
  assign r_hits    = HITS_W'(popcount(POP_W_MAX'(mask_q)));

endmodule

// File: tb/tb_prm_edge_mask_engine.sv
// Scoreboard bench for prm_edge_mask_engine: a table model predicts each
// result, a monitor compares whenever a result is handed over.
module tb_prm_edge_mask_engine;

  localparam int unsigned IN_W     = 15;
  localparam int unsigned N_EDGE   = 8;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned LANES    = 2;
  localparam int unsigned SCAN_LEN = DEPTH / LANES;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned EDGE_W   = 3;
  localparam int unsigned HITS_W   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_we, cfg_clr, cfg_en, cfg_ready;
  logic [ADDR_W-1:0] cfg_addr;
  logic [IN_W-1:0]   cfg_care, cfg_val;
  logic [EDGE_W-1:0] cfg_edge;
  logic              q_valid, q_ready, r_valid, r_ready;
  logic [IN_W-1:0]   q_vec;
  logic [N_EDGE-1:0] r_mask;
  logic [HITS_W-1:0] r_hits;

  int checks = 0;
  int errors = 0;

  logic [N_EDGE-1:0] exp_q [$];

  logic [IN_W-1:0]   m_care [DEPTH];
  logic [IN_W-1:0]   m_val  [DEPTH];
  logic [EDGE_W-1:0] m_edge [DEPTH];
  logic              m_en   [DEPTH];

  logic              side_we;
  logic [ADDR_W-1:0] side_addr;
  logic [IN_W-1:0]   side_care, side_val;
  logic [EDGE_W-1:0] side_edge;
  logic              side_en;

  always #5 clk = ~clk;

  prm_edge_mask_engine #(
    .IN_W(IN_W), .N_EDGE(N_EDGE), .DEPTH(DEPTH), .LANES(LANES)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_clr(cfg_clr), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_care(cfg_care), .cfg_val(cfg_val),
    .cfg_edge(cfg_edge), .cfg_en(cfg_en),
    .q_valid(q_valid), .q_ready(q_ready), .q_vec(q_vec),
    .r_valid(r_valid), .r_ready(r_ready),
    .r_mask(r_mask), .r_hits(r_hits)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference: OR of the edge bits of every enabled cube the vector satisfies.
  function automatic logic [N_EDGE-1:0] model_mask(input logic [IN_W-1:0] v);
    logic [N_EDGE-1:0] m;
    m = '0;
    for (int i = 0; i < DEPTH; i++)
      if (m_en[i] && (((v ^ m_val[i]) & m_care[i]) == '0)) m[m_edge[i]] = 1'b1;
    return m;
  endfunction

  task automatic model_cfg(input logic clr, input logic we, input logic [ADDR_W-1:0] a,
                           input logic [IN_W-1:0] care, input logic [IN_W-1:0] val,
                           input logic [EDGE_W-1:0] e, input logic en);
    if (clr) for (int i = 0; i < DEPTH; i++) m_en[i] = 1'b0;
    if (we) begin
      m_care[a] = care; m_val[a] = val; m_edge[a] = e; m_en[a] = en;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!q_ready && n < 20) begin
      tick();
      n++;
    end
    check("q_ready_wait", 32'(q_ready), 32'd1);
  endtask

  task automatic cfg_write(input logic clr, input logic we, input logic [ADDR_W-1:0] a,
                           input logic [IN_W-1:0] care, input logic [IN_W-1:0] val,
                           input logic [EDGE_W-1:0] e, input logic en);
    wait_ready();
    cfg_clr = clr; cfg_we = we; cfg_addr = a;
    cfg_care = care; cfg_val = val; cfg_edge = e; cfg_en = en;
    model_cfg(clr, we, a, care, val, e, en);
    tick();
    cfg_clr = 1'b0; cfg_we = 1'b0;
  endtask

  // Config pulse that would change every result if it were honoured.
  task automatic junk_cfg();
    cfg_we = 1'b1; cfg_clr = 1'b1; cfg_addr = ADDR_W'($urandom);
    cfg_care = '0; cfg_val = IN_W'($urandom); cfg_edge = EDGE_W'($urandom); cfg_en = 1'b1;
  endtask

  task automatic run_query(input logic [IN_W-1:0] v, input int hold);
    int n;
    logic [N_EDGE-1:0] e;
    wait_ready();
    r_ready = (hold == 0);
    q_valid = 1'b1; q_vec = v;
    if (side_we) begin
      cfg_we = 1'b1; cfg_addr = side_addr; cfg_care = side_care;
      cfg_val = side_val; cfg_edge = side_edge; cfg_en = side_en;
      model_cfg(1'b0, 1'b1, side_addr, side_care, side_val, side_edge, side_en);
    end
    e = model_mask(v);
    exp_q.push_back(e);
    tick();
    q_valid = 1'b0; cfg_we = 1'b0; q_vec = IN_W'($urandom);
    junk_cfg();
    tick();
    cfg_we = 1'b0; cfg_clr = 1'b0;
    n = 1;
    while (!r_valid && n < 20) begin
      tick();
      n++;
    end
    check("latency", 32'(n), 32'(SCAN_LEN));
    for (int h = 0; h < hold; h++) begin
      junk_cfg();
      tick();
      cfg_we = 1'b0; cfg_clr = 1'b0;
      check("hold_valid", 32'(r_valid), 32'd1);
      check("hold_mask", 32'(r_mask), 32'(e));
      check("hold_q_ready", 32'(q_ready), 32'd0);
      check("hold_cfg_ready", 32'(cfg_ready), 32'd0);
    end
    r_ready = 1'b1;
    tick();
    check("r_valid_drop", 32'(r_valid), 32'd0);
  endtask

  // Monitor: compare every handed-over result against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && r_valid && r_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual_mask=0x%0h required=none", r_mask);
      end else begin
        logic [N_EDGE-1:0] e;
        e = exp_q.pop_front();
        check("r_mask", 32'(r_mask), 32'(e));
        check("r_hits", 32'(r_hits), 32'($countones(e)));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IN_W-1:0] v;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_clr = 1'b0; cfg_en = 1'b0;
    cfg_addr = '0; cfg_care = '0; cfg_val = '0; cfg_edge = '0;
    q_valid = 1'b0; q_vec = '0; r_ready = 1'b1; side_we = 1'b0;
    side_addr = '0; side_care = '0; side_val = '0; side_edge = '0; side_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      m_care[i] = '0; m_val[i] = '0; m_edge[i] = '0; m_en[i] = 1'b0;
    end

    repeat (3) tick();
    check("rst_q_ready", 32'(q_ready), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    check("rst_r_valid", 32'(r_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_q_ready", 32'(q_ready), 32'd1);
    check("post_rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("post_rst_mask", 32'(r_mask), 32'd0);
    check("post_rst_hits", 32'(r_hits), 32'd0);

    run_query(15'h0000, 0);
    cfg_write(1'b0, 1'b1, 3'd0, 15'h7FFF, 15'h1234, 3'd3, 1'b1);
    run_query(15'h1234, 0);
    run_query(15'h1235, 0);
    cfg_write(1'b0, 1'b1, 3'd1, 15'h0001, 15'h0001, 3'd5, 1'b1);
    cfg_write(1'b0, 1'b1, 3'd7, 15'h0000, 15'h0000, 3'd5, 1'b1);
    run_query(15'h1234, 3);
    run_query(15'h1234, 0);

    // Reset during the second scan cycle drops the query and empties the table.
    wait_ready();
    q_valid = 1'b1; q_vec = 15'h1234;
    tick();
    q_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("midscan_rst_q_ready", 32'(q_ready), 32'd0);
    check("midscan_rst_r_valid", 32'(r_valid), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) m_en[i] = 1'b0;
    tick();
    check("release_q_ready", 32'(q_ready), 32'd1);
    for (int i = 0; i < SCAN_LEN + 2; i++) begin
      tick();
      check("dropped_no_r_valid", 32'(r_valid), 32'd0);
    end
    run_query(15'h1234, 0);

    cfg_write(1'b0, 1'b1, 3'd4, 15'h0000, 15'h0000, 3'd1, 1'b1);
    cfg_write(1'b1, 1'b1, 3'd2, 15'h0000, 15'h0000, 3'd6, 1'b1);
    run_query(IN_W'($urandom), 0);

    for (int it = 0; it < 40; it++) begin
      int nw;
      nw = int'($urandom_range(0, 2));
      for (int k = 0; k < nw; k++)
        cfg_write(($urandom % 10) == 0, 1'b1, ADDR_W'($urandom),
                  IN_W'($urandom) & IN_W'($urandom) & IN_W'($urandom),
                  IN_W'($urandom), EDGE_W'($urandom), ($urandom % 5) != 0);
      side_we   = ($urandom % 4) == 0;
      side_addr = ADDR_W'($urandom);
      side_care = IN_W'($urandom) & IN_W'($urandom);
      side_val  = IN_W'($urandom);
      side_edge = EDGE_W'($urandom);
      side_en   = 1'b1;
      if ($urandom % 2 == 0) v = IN_W'($urandom);
      else v = m_val[$urandom_range(0, DEPTH - 1)];
      run_query(v, int'($urandom_range(0, 2)));
      side_we = 1'b0;
    end

    tick();
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
